target_sprite_mapper: RTL and testbench

TARGET_SPRITE_MAPPER -- requirements
Module: target_sprite_mapper

---
 rtl/target_pkg.sv | 20 ++
 rtl/target_hit_test.sv | 42 ++++
 rtl/target_sprite_mapper.sv | 182 ++++++++++++++++++
 tb/tb_target_sprite_mapper.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/target_pkg.sv
// Shared constants for the target sprite mapper.
//   COORD_W     : pixel/target coordinate width
//   INBLK_W     : texel address width inside a block
//   DEF_*       : default values for the mapper parameters
//   clog2_min1  : ceil(log2(v)) clamped to at least 1 bit
package target_pkg;

    localparam int unsigned COORD_W         = 10;
    localparam int unsigned INBLK_W         = 10;
    localparam int unsigned DEF_N_TARGETS   = 4;
    localparam int unsigned DEF_BLOCK_LOG2  = 5;
    localparam int unsigned DEF_GRID        = 3;
    localparam int unsigned DEF_Y_LIMIT     = 385;
    localparam int unsigned DEF_ADDR_OFFSET = 2;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/target_hit_test.sv
// Combinational coverage test of one target against the current pixel.
//   fx, fy        : current pixel coordinate
//   tx, ty, en    : shadowed target position and enable
//   pixel_valid   : pixel is visible this cycle
//   hit           : target covers the pixel
//   dx, dy        : pixel offset from target origin (meaningful only when hit)
module target_hit_test
    import target_pkg::*;
#(
    parameter int unsigned SPAN    = 96,
    parameter int unsigned Y_LIMIT = 385
) (
    input  logic [COORD_W-1:0] fx,
    input  logic [COORD_W-1:0] fy,
    input  logic [COORD_W-1:0] tx,
    input  logic [COORD_W-1:0] ty,
    input  logic               en,
    input  logic               pixel_valid,
    output logic               hit,
    output logic [COORD_W-1:0] dx,
    output logic [COORD_W-1:0] dy
);

    localparam logic [COORD_W:0] SPAN_W = (COORD_W + 1)'(SPAN);
    localparam logic [COORD_W:0] YLIM_W = (COORD_W + 1)'(Y_LIMIT);

    // One extra bit so a target near 1023 extends past the edge instead of wrapping.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, tx} + SPAN_W;
    assign y_end = {1'b0, ty} + SPAN_W;

    assign hit = en & pixel_valid
               & (fx >= tx) & ({1'b0, fx} < x_end)
               & (fy >= ty) & ({1'b0, fy} < y_end)
               & ({1'b0, fy} < YLIM_W);

    assign dx = fx - tx;
    assign dy = fy - ty;

endmodule

// File: rtl/target_sprite_mapper.sv
// Maps the current pixel onto up to N_TARGETS square sprites (GRID x GRID
// blocks of 2^BLOCK_LOG2 pixels). Two-stage pipeline, one pixel per cycle.
//   clk, reset           : clock, synchronous active-high reset
//   frame_start          : latches target positions/enables into shadow regs
//   pixel_valid, frame_x/y : pixel stream
//   target_x/y, target_enable : packed live target parameters
//   hit_valid, hit_id    : a target covers the pixel issued 2 cycles earlier
//   block_coord          : block index within the winning sprite
//   inblock_coord        : texel address within the block (+ADDR_OFFSET)
//   overlap              : more than one target covers the pixel
//   hit_count            : per-target win counts of the previous frame,
//                          present only when TARGET_HIT_COUNT_EN is defined
module target_sprite_mapper
    import target_pkg::*;
#(
    parameter int unsigned N_TARGETS   = DEF_N_TARGETS,
    parameter int unsigned BLOCK_LOG2  = DEF_BLOCK_LOG2,
    parameter int unsigned GRID        = DEF_GRID,
    parameter int unsigned Y_LIMIT     = DEF_Y_LIMIT,
    parameter int unsigned ADDR_OFFSET = DEF_ADDR_OFFSET,
    localparam int unsigned ID_W       = clog2_min1(N_TARGETS),
    localparam int unsigned BLK_W      = clog2_min1(GRID * GRID)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           pixel_valid,
    input  logic [COORD_W-1:0]             frame_x,
    input  logic [COORD_W-1:0]             frame_y,
    input  logic [COORD_W*N_TARGETS-1:0]   target_x,
    input  logic [COORD_W*N_TARGETS-1:0]   target_y,
    input  logic [N_TARGETS-1:0]           target_enable,
    output logic                           hit_valid,
    output logic [ID_W-1:0]                hit_id,
    output logic [BLK_W-1:0]               block_coord,
    output logic [INBLK_W-1:0]             inblock_coord,
    output logic                           overlap
`ifdef TARGET_HIT_COUNT_EN
    ,
    output logic [16*N_TARGETS-1:0]        hit_count
`endif
);

    localparam int unsigned SPAN = GRID * (1 << BLOCK_LOG2);
    localparam logic [COORD_W-1:0] BMASK = COORD_W'((1 << BLOCK_LOG2) - 1);

    // Shadow copies of the target parameters, stable for a whole frame.
    logic [COORD_W*N_TARGETS-1:0] sh_x;
    logic [COORD_W*N_TARGETS-1:0] sh_y;
    logic [N_TARGETS-1:0]         sh_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_x  <= '0;
            sh_y  <= '0;
            sh_en <= '0;
        end else if (frame_start) begin
            sh_x  <= target_x;
            sh_y  <= target_y;
            sh_en <= target_enable;
        end
    end

    // Stage 1: per-target compare/subtract.
    logic [N_TARGETS-1:0] hit_c;
    logic [COORD_W-1:0]   dx_c [N_TARGETS];
    logic [COORD_W-1:0]   dy_c [N_TARGETS];

    for (genvar g = 0; g < N_TARGETS; g++) begin : gen_hit
        target_hit_test #(
            .SPAN    (SPAN),
            .Y_LIMIT (Y_LIMIT)
        ) u_hit_test (
            .fx          (frame_x),
            .fy          (frame_y),
            .tx          (sh_x[g*COORD_W +: COORD_W]),
            .ty          (sh_y[g*COORD_W +: COORD_W]),
            .en          (sh_en[g]),
            .pixel_valid (pixel_valid),
            .hit         (hit_c[g]),
            .dx          (dx_c[g]),
            .dy          (dy_c[g])
        );
    end

    logic [N_TARGETS-1:0] s1_hit;
    logic [COORD_W-1:0]   s1_dx [N_TARGETS];
    logic [COORD_W-1:0]   s1_dy [N_TARGETS];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit <= '0;
            for (int i = 0; i < N_TARGETS; i++) begin
                s1_dx[i] <= '0;
                s1_dy[i] <= '0;
            end
        end else begin
            s1_hit <= hit_c;
            for (int i = 0; i < N_TARGETS; i++) begin
                s1_dx[i] <= dx_c[i];
                s1_dy[i] <= dy_c[i];
            end
        end
    end

    // Stage 2: fixed-priority select, lowest index wins.
    logic               win_valid;
    logic               win_multi;
    logic [ID_W-1:0]    win_id;
    logic [COORD_W-1:0] win_dx;
    logic [COORD_W-1:0] win_dy;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic [BLK_W-1:0]   block_c;
    logic [INBLK_W-1:0] inblock_c;

    always_comb begin
        win_valid = 1'b0;
        win_multi = 1'b0;
        win_id    = '0;
        win_dx    = '0;
        win_dy    = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (s1_hit[i]) begin
                if (win_valid) begin
                    win_multi = 1'b1;
                end else begin
                    win_valid = 1'b1;
                    win_id    = ID_W'(i);
                    win_dx    = s1_dx[i];
                    win_dy    = s1_dy[i];
                end
            end
        end
    end

    assign bx        = win_dx >> BLOCK_LOG2;
    assign by        = win_dy >> BLOCK_LOG2;
    assign block_c   = BLK_W'(32'(bx) + GRID * 32'(by));
    assign inblock_c = INBLK_W'(32'(win_dx & BMASK) + (32'(win_dy & BMASK) << BLOCK_LOG2)
                                + ADDR_OFFSET);

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_valid     <= 1'b0;
            hit_id        <= '0;
            block_coord   <= '0;
            inblock_coord <= '0;
            overlap       <= 1'b0;
        end else begin
            hit_valid     <= win_valid;
            hit_id        <= win_id;
            block_coord   <= win_valid ? block_c : '0;
            inblock_coord <= win_valid ? inblock_c : '0;
            overlap       <= win_multi;
        end
    end

`ifdef TARGET_HIT_COUNT_EN
    // Per-target saturating win counters, snapshotted and cleared per frame.
    logic [15:0] cnt [N_TARGETS];

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count <= '0;
            for (int i = 0; i < N_TARGETS; i++) cnt[i] <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < N_TARGETS; i++) begin
                hit_count[16*i +: 16] <= cnt[i];
                cnt[i]                <= '0;
            end
        end else begin
            for (int i = 0; i < N_TARGETS; i++) begin
                if (win_valid && (win_id == ID_W'(i)) && (cnt[i] != 16'hffff)) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_target_sprite_mapper.sv
// Directed self-checking bench for target_sprite_mapper (default parameters:
// 4 targets, 32-pixel blocks, 3x3 grid -> 96-pixel span, Y_LIMIT 385, offset 2).
// Also exercises hit_count when TARGET_HIT_COUNT_EN is defined.
module tb_target_sprite_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        pixel_valid;
    logic [9:0]  frame_x;
    logic [9:0]  frame_y;
    logic [39:0] target_x;
    logic [39:0] target_y;
    logic [3:0]  target_enable;
    logic        hit_valid;
    logic [1:0]  hit_id;
    logic [3:0]  block_coord;
    logic [9:0]  inblock_coord;
    logic        overlap;
`ifdef TARGET_HIT_COUNT_EN
    logic [63:0] hit_count;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    target_sprite_mapper dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .pixel_valid   (pixel_valid),
        .frame_x       (frame_x),
        .frame_y       (frame_y),
        .target_x      (target_x),
        .target_y      (target_y),
        .target_enable (target_enable),
        .hit_valid     (hit_valid),
        .hit_id        (hit_id),
        .block_coord   (block_coord),
        .inblock_coord (inblock_coord),
        .overlap       (overlap)
`ifdef TARGET_HIT_COUNT_EN
        ,
        .hit_count     (hit_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic v, input int id, input int blk,
                              input int inb, input logic ov);
        chk({tag, "_valid"},   32'(hit_valid),     32'(v));
        chk({tag, "_id"},      32'(hit_id),        id);
        chk({tag, "_block"},   32'(block_coord),   blk);
        chk({tag, "_inblock"}, 32'(inblock_coord), inb);
        chk({tag, "_overlap"}, 32'(overlap),       32'(ov));
    endtask

    task automatic set_target(input int i, input int x, input int y);
        target_x[i*10 +: 10] = 10'(x);
        target_y[i*10 +: 10] = 10'(y);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Issue one pixel at a negedge; returns two edges later with its result visible.
    task automatic issue(input int x, input int y, input logic fs);
        frame_x     = 10'(x);
        frame_y     = 10'(y);
        pixel_valid = 1'b1;
        frame_start = fs;
        @(negedge clk);
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0;
        frame_x = '0; frame_y = '0;
        target_x = '0; target_y = '0; target_enable = '0;
        repeat (3) @(negedge clk);
        expect_out("reset", 1'b0, 0, 0, 0, 1'b0);
        reset = 1'b0;

        // Shadow enables are clear until the first frame_start.
        set_target(0, 100, 50);
        target_enable = 4'b0001;
        issue(133, 115, 1'b0);
        chk("pre_frame_valid", 32'(hit_valid), 0);

        pulse_fs();
        issue(133, 115, 1'b0);
        expect_out("basic", 1'b1, 0, 7, 35, 1'b0);
        issue(100, 50, 1'b0);
        expect_out("origin", 1'b1, 0, 0, 2, 1'b0);
        issue(195, 145, 1'b0);  // last texel: 31+32*31+2 = 1025 -> 1 after truncation
        expect_out("corner", 1'b1, 0, 8, 1, 1'b0);
        issue(196, 50, 1'b0);
        chk("right_edge_valid", 32'(hit_valid), 0);
        issue(99, 50, 1'b0);
        chk("left_edge_valid", 32'(hit_valid), 0);

        // Two overlapping targets: lower index wins.
        set_target(1, 200, 200);
        set_target(2, 200, 200);
        target_enable = 4'b0110;
        pulse_fs();
        issue(210, 210, 1'b0);
        expect_out("overlap", 1'b1, 1, 0, 332, 1'b1);

        // Target near the right edge must not wrap around.
        set_target(0, 1000, 10);
        target_enable = 4'b0001;
        pulse_fs();
        issue(5, 20, 1'b0);
        expect_out("nowrap", 1'b0, 0, 0, 0, 1'b0);
        issue(1023, 20, 1'b0);
        expect_out("edge", 1'b1, 0, 0, 345, 1'b0);

        // Mid-frame change is ignored until the next frame_start.
        set_target(0, 500, 10);
        issue(1023, 20, 1'b0);
        chk("shadow_old_valid", 32'(hit_valid), 1);
        issue(510, 20, 1'b0);
        chk("shadow_new_early_valid", 32'(hit_valid), 0);
        pulse_fs();
        issue(510, 20, 1'b0);
        expect_out("shadow_new", 1'b1, 0, 0, 332, 1'b0);
        issue(1023, 20, 1'b0);
        chk("shadow_old_gone_valid", 32'(hit_valid), 0);

        // Y_LIMIT row cut-off.
        set_target(0, 0, 380);
        pulse_fs();
        issue(10, 385, 1'b0);
        chk("ylimit_valid", 32'(hit_valid), 0);
        issue(10, 384, 1'b0);
        expect_out("below_ylimit", 1'b1, 0, 0, 140, 1'b0);

        // Pixel coincident with frame_start still uses the old shadow.
        set_target(0, 600, 380);
        issue(10, 384, 1'b1);
        chk("fs_coincident_valid", 32'(hit_valid), 1);
        issue(10, 384, 1'b0);
        chk("fs_after_valid", 32'(hit_valid), 0);

        // Back-to-back pixels including a bubble.
        set_target(0, 0, 0);
        pulse_fs();
        frame_x = 10; frame_y = 10; pixel_valid = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        @(negedge clk);
        expect_out("pipe_a", 1'b1, 0, 0, 332, 1'b0);
        frame_x = 200; frame_y = 10; pixel_valid = 1'b1;
        @(negedge clk);
        chk("pipe_bubble_valid", 32'(hit_valid), 0);
        frame_x = 20; frame_y = 10; pixel_valid = 1'b1;
        @(negedge clk);
        chk("pipe_c_valid", 32'(hit_valid), 0);
        pixel_valid = 1'b0;
        @(negedge clk);
        expect_out("pipe_d", 1'b1, 0, 0, 342, 1'b0);

        // Reset with pixels in flight.
        frame_x = 10; frame_y = 10; pixel_valid = 1'b1;
        @(negedge clk);
        frame_x = 11;
        @(negedge clk);
        chk("pre_reset_valid", 32'(hit_valid), 1);
        reset = 1'b1; pixel_valid = 1'b0;
        @(negedge clk);
        expect_out("in_reset", 1'b0, 0, 0, 0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("flushed_valid", 32'(hit_valid), 0);
        issue(10, 10, 1'b0);
        chk("post_reset_valid", 32'(hit_valid), 0);
        pulse_fs();
        issue(10, 10, 1'b0);
        chk("refresh_valid", 32'(hit_valid), 1);

`ifdef TARGET_HIT_COUNT_EN
        // Sweep every pixel of the 96x96 sprite, then snapshot.
        pulse_fs();
        for (int y = 0; y < 96; y++) begin
            for (int x = 0; x < 96; x++) begin
                frame_x = 10'(x); frame_y = 10'(y); pixel_valid = 1'b1;
                @(negedge clk);
            end
        end
        pixel_valid = 1'b0;
        repeat (3) @(negedge clk);
        pulse_fs();
        chk("hit_count0", 32'(hit_count[15:0]), 9216);
        chk("hit_count1", 32'(hit_count[31:16]), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
